// File: rtl/seq_alu.sv
// seq_alu: registered ALU with iterative unsigned multiply, divide and remainder.
// Latency: 1 cycle for single-cycle ops and divide-by-zero; WIDTH cycles for mul/divu/remu.
// Backpressure: none; start is accepted only while busy=0, and start during busy is dropped.
// Optional: define SEQ_ALU_OVERFLOW_EN to add the registered signed-overflow output for add/sub.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
`ifdef SEQ_ALU_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_SLTU = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;
  localparam logic [3:0] OP_REMU = 4'd14;

  // Iteration counter start value: WIDTH steps, counting down to 0.
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  // MUL: opa = shifted multiplicand, opb = multiplier, acc = running product.
  // DIV: opa = dividend shifting out / quotient shifting in, opb = divisor, acc = partial remainder.
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic             rem_sel;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             is_div_op;

  logic [WIDTH-1:0] mul_next;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] div_res;

  assign shamt     = num2[SHW-1:0];
  assign sum       = num1 + num2;
  assign diff      = num1 - num2;
  assign is_div_op = (op == OP_DIVU) || (op == OP_REMU);

  // Single-cycle result; divu/remu entries only matter for the divide-by-zero shortcut.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = num1 & num2;
      OP_OR:   alu_res = num1 | num2;
      OP_NOT:  alu_res = ~num1;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (num1 < num2)};
      OP_XOR:  alu_res = num1 ^ num2;
      OP_NOR:  alu_res = ~(num1 | num2);
      OP_SLL:  alu_res = num1 << shamt;
      OP_SRL:  alu_res = num1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(num1) >>> shamt);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(num1) < $signed(num2))};
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = num1;
      default: alu_res = '0;
    endcase
  end

  // Two's-complement overflow flag for add/sub, zero for every other op.
  always_comb begin
    alu_ovf = 1'b0;
    if (op == OP_ADD)
      alu_ovf = (num1[WIDTH-1] == num2[WIDTH-1]) && (sum[WIDTH-1] != num1[WIDTH-1]);
    else if (op == OP_SUB)
      alu_ovf = (num1[WIDTH-1] != num2[WIDTH-1]) && (diff[WIDTH-1] != num1[WIDTH-1]);
  end

  // One shift-and-add step (LSB first) and one restoring-division step (MSB first).
  always_comb begin
    mul_next = acc + (opb[0] ? opa : '0);
    trial    = {acc, opa[WIDTH-1]} - {1'b0, opb};
    rem_next = trial[WIDTH] ? {acc[WIDTH-2:0], opa[WIDTH-1]} : trial[WIDTH-1:0];
    quo_next = {opa[WIDTH-2:0], ~trial[WIDTH]};
    div_res  = rem_sel ? rem_next : quo_next;
  end

  // Control FSM with registered result, zero, busy and done; reset aborts any iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result   <= '0;
      zero     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      rem_sel  <= 1'b0;
`ifdef SEQ_ALU_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              opa   <= num1;
              opb   <= num2;
              acc   <= '0;
              cnt   <= CNT_LAST;
              busy  <= 1'b1;
              state <= MUL;
            end else if (is_div_op && (num2 != '0)) begin
              opa     <= num1;
              opb     <= num2;
              acc     <= '0;
              rem_sel <= (op == OP_REMU);
              cnt     <= CNT_LAST;
              busy    <= 1'b1;
              state   <= DIV;
            end else begin
              result   <= alu_res;
              zero     <= (alu_res == '0);
              done     <= 1'b1;
`ifdef SEQ_ALU_OVERFLOW_EN
              overflow <= alu_ovf;
`endif
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          opa <= opa << 1;
          opb <= opb >> 1;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result   <= mul_next;
            zero     <= (mul_next == '0);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
`ifdef SEQ_ALU_OVERFLOW_EN
            overflow <= 1'b0;
`endif
          end
        end
        DIV: begin
          acc <= rem_next;
          opa <= quo_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            result   <= div_res;
            zero     <= (div_res == '0);
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
`ifdef SEQ_ALU_OVERFLOW_EN
            overflow <= 1'b0;
`endif
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SEQ_ALU_OVERFLOW_EN
  // Overflow logic has no consumer in this build.
  logic unused_ovf;
  assign unused_ovf = alu_ovf;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu (WIDTH=32): directed vectors with literal expectations,
// plus a cycle-level reference model checked against the DUT on every cycle.
module tb_seq_alu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  num1;
  logic [W-1:0]  num2;
  logic [3:0]    op;
  logic [W-1:0]  result;
  logic          zero;
  logic          busy;
  logic          done;
`ifdef SEQ_ALU_OVERFLOW_EN
  logic          overflow;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  seq_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .num1   (num1),
    .num2   (num2),
    .op     (op),
    .result (result),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
`ifdef SEQ_ALU_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of each opcode, written with plain operators.
  function automatic logic [W-1:0] ref_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return ~a;
      4'd5:  return (a < b) ? 32'd1 : 32'd0;
      4'd6:  return a ^ b;
      4'd7:  return ~(a | b);
      4'd8:  return a << b[4:0];
      4'd9:  return a >> b[4:0];
      4'd10: return 32'($signed(a) >>> b[4:0]);
      4'd11: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: return a * b;
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Signed overflow judged on the true mathematical sum/difference.
  function automatic logic ref_ovf(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 4'd0) r = sa + sb;
    else if (o == 4'd1) r = sa - sb;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  // Reference model: an accepted multi-cycle op completes WIDTH edges after the sampling edge.
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_pend = '0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         m_ovf = 1'b0;
  int           m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_res = '0; m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_res = m_pend; m_ovf = 1'b0;
        end
      end else if (start) begin
        if (op == 4'd12 || ((op == 4'd13 || op == 4'd14) && num2 != 0)) begin
          m_busy = 1'b1; m_left = W; m_pend = ref_op(op, num1, num2);
        end else begin
          m_done = 1'b1; m_res = ref_op(op, num1, num2); m_ovf = ref_ovf(op, num1, num2);
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_result", result, m_res);
      check("cyc_zero", 32'(zero), 32'(m_res == 0));
`ifdef SEQ_ALU_OVERFLOW_EN
      check("cyc_overflow", 32'(overflow), 32'(m_ovf));
`endif
    end
  end

  // Issue one op, wait (bounded) for done; lat counts negedges from the start cycle.
  task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_lat,
                        input int exp_busy);
    int lat;
    int nb;
    start = 1'b1; op = o; num1 = a; num2 = b;
    @(negedge clk);
    start = 1'b0;
    lat = 1; nb = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
      lat++;
    end
    check({name, "_done_seen"}, 32'(done), 32'd1);
    check({name, "_result"}, result, exp);
    check({name, "_zero"}, 32'(zero), 32'(exp == 0));
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; op = '0; num1 = '0; num2 = '0;
    repeat (2) @(negedge clk);
    check("reset_result", result, 32'd0);
    check("reset_zero", 32'(zero), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single-cycle ops: latency 1, never busy.
    run_op("sub_5_5",   4'd1,  32'd5,          32'd5,  32'd0,          1, 0);
    run_op("add_one",   4'd0,  32'd2,          32'd3,  32'd5,          1, 0);
    run_op("add_wrap",  4'd0,  32'hFFFF_FFFF,  32'd1,  32'd0,          1, 0);
    run_op("sra_4",     4'd10, 32'h8000_0000,  32'd4,  32'hF800_0000,  1, 0);
    run_op("slt_neg",   4'd11, 32'hFFFF_FFFF,  32'd1,  32'd1,          1, 0);
    run_op("sltu_big",  4'd5,  32'hFFFF_FFFF,  32'd1,  32'd0,          1, 0);
    run_op("sll_33",    4'd8,  32'd1,          32'd33, 32'd2,          1, 0);
    run_op("srl_4",     4'd9,  32'h8000_0000,  32'd4,  32'h0800_0000,  1, 0);
    run_op("xor",       4'd6,  32'hF0F0_1234,  32'hFF00_1234, 32'h0FF0_0000, 1, 0);
    run_op("nor",       4'd7,  32'hF0F0_0000,  32'h0F0F_0000, 32'h0000_FFFF, 1, 0);
    run_op("not",       4'd4,  32'h0000_00FF,  32'd0,  32'hFFFF_FF00,  1, 0);
    run_op("and",       4'd2,  32'hFF00_FF00,  32'h0FF0_0FF0, 32'h0F00_0F00, 1, 0);
    run_op("or",        4'd3,  32'hFF00_0000,  32'h0000_00FF, 32'hFF00_00FF, 1, 0);
    run_op("reserved",  4'd15, 32'd7,          32'd9,  32'd0,          1, 0);

    // Multi-cycle ops: done WIDTH edges after the sampling edge, busy for WIDTH cycles.
    run_op("mul",       4'd12, 32'h0001_0003,  32'd5,  32'h0005_000F,  W+1, W);
    run_op("mul_wrap",  4'd12, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,   W+1, W);
    run_op("divu",      4'd13, 32'd100,        32'd7,  32'd14,         W+1, W);
    run_op("remu",      4'd14, 32'd100,        32'd7,  32'd2,          W+1, W);
    run_op("divu_big",  4'd13, 32'hFFFF_FFFF,  32'd16, 32'h0FFF_FFFF,  W+1, W);
    run_op("remu_zero", 4'd14, 32'd21,         32'd7,  32'd0,          W+1, W);
    run_op("divu_by0",  4'd13, 32'd9,          32'd0,  32'hFFFF_FFFF,  1, 0);
    run_op("remu_by0",  4'd14, 32'd9,          32'd0,  32'd9,          1, 0);

    // A start during busy (with different operands) is dropped.
    start = 1'b1; op = 4'd12; num1 = 32'd7; num2 = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 4'd0; num1 = 32'd1; num2 = 32'd1;
    @(negedge clk);
    start = 1'b0; num1 = 32'd99; num2 = 32'd99;
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("ignore_done_seen", 32'(done), 32'd1);
    check("ignore_result", result, 32'd42);
    check("ignore_latency", 32'(n + 6), 32'(W + 1));
    @(negedge clk);
    check("ignore_no_extra_done", 32'(done), 32'd0);

    // Back-to-back: add issued in the done cycle of a mul.
    start = 1'b1; op = 4'd12; num1 = 32'd3; num2 = 32'd4;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("b2b_mul_result", result, 32'd12);
    start = 1'b1; op = 4'd0; num1 = 32'd10; num2 = 32'd20;
    @(negedge clk);
    start = 1'b0;
    check("b2b_add_done", 32'(done), 32'd1);
    check("b2b_add_result", result, 32'd30);

    // Reset in the middle of a divide discards it.
    start = 1'b1; op = 4'd13; num1 = 32'd1000; num2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_zero", 32'(zero), 32'd1);
    run_op("after_abort", 4'd14, 32'd1000, 32'd3, 32'd1, W+1, W);

`ifdef SEQ_ALU_OVERFLOW_EN
    run_op("ovf_add", 4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1, 0);
    check("ovf_add_flag", 32'(overflow), 32'd1);
    run_op("ovf_sub", 4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1, 0);
    check("ovf_sub_flag", 32'(overflow), 32'd1);
    run_op("ovf_none", 4'd0, 32'd2, 32'd3, 32'd5, 1, 0);
    check("ovf_none_flag", 32'(overflow), 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle ALU in the CPU datapath.
- Widens the opcode to 4 bits and adds XOR, NOR, shifts and signed compare.
- Adds iterative unsigned multiply, divide and remainder.
- Uses a start/busy/done handshake so the control unit can stall the pipeline while a multi-cycle operation runs.

Parameters:
- WIDTH, 32: operand and result width in bits; must be at least 4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; operands and op are sampled when start=1 and busy=0.
- num1  input  WIDTH  operand A.
- num2  input  WIDTH  operand B.
- op  input  4  operation select.
- result  output  WIDTH  registered result; holds until the next completion.
- zero  output  1  registered; equals 1 when result == 0, updated together with result.
- busy  output  1  a multi-cycle operation is in progress.
- done  output  1  one-cycle pulse; result and zero are valid from this cycle.

Behaviour:
- Reset: on a clk edge with rst=1, result=0, zero=1, busy=0, done=0 and state=IDLE. Reset takes priority over every other event, aborts any in-flight operation and discards its partial result.
- Opcodes, all unsigned unless stated:
  - 0 add, 1 sub, 2 and, 3 or, 4 ~num1.
  - 5 sltu: 1 if num1<num2, else 0.
  - 6 xor, 7 nor.
  - 8 sll by num2[SHW-1:0], 9 srl, 10 sra (arithmetic).
  - 11 slt (signed compare, result 1/0).
  - 12 mul: low WIDTH bits of the product.
  - 13 divu quotient, 14 remu remainder.
  - 15 reserved: result 0.
- Add and sub wrap modulo 2^WIDTH. No carry output.
- States: IDLE, MUL, DIV.
- IDLE:
  - start=1 with op in {0..11, 15}: compute combinationally from the sampled operands. Register result and zero, and pulse done=1 in the next cycle. Remain in IDLE; busy stays 0. Latency is 1 cycle.
  - start=1 with op=12: latch operands, clear the accumulator, load cnt=WIDTH-1, set busy=1 and go to MUL.
  - start=1 with op in {13, 14}: if num2==0, go straight to the divide-by-zero completion (below). Otherwise latch operands and the quotient/remainder select, clear the partial remainder, load cnt=WIDTH-1, set busy=1 and go to DIV.
- MUL: each cycle, shift-and-add one multiplier bit, LSB first.
- DIV: each cycle, perform one restoring-division step, MSB first.
- MUL and DIV both decrement cnt each cycle. The step with cnt==0 is the last: write result and zero, pulse done=1, clear busy and return to IDLE.
- Multi-cycle latency: done rises exactly WIDTH cycles after the start-sampling edge, i.e. done is high in the cycle after the WIDTH-th iteration.
- Divide by zero: completes with 1-cycle latency and busy never asserts. divu returns all ones; remu returns num1.
- start while busy=1 is ignored; no queueing, and operand changes have no effect.
- start sampled in the same cycle that done=1 is accepted, giving back-to-back operation.
- done is 0 in every cycle except completion cycles.
- result and zero change only on completion or reset.

Optional Feature:
- Macro SEQ_ALU_OVERFLOW_EN.
- When defined:
  - Adds output port overflow (1 bit), registered with result and reset to 0.
  - For op 0/1 it is set to two's-complement signed overflow: operand signs equal and the result sign differs (add), or operand signs differ and the result sign differs from num1 (sub).
  - It is 0 for all other ops.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset and single-cycle: assert rst for 2 cycles -> result=0, zero=1, busy=0, done=0. Then start with op=1, num1=5, num2=5 -> next cycle done=1, result=0, zero=1. Then op=0, 0xFFFFFFFF+1 -> result=0 (wrap), zero=1.
2. Shifts and compares: sra 0x80000000 by 4 -> 0xF8000000. slt 0xFFFFFFFF vs 1 -> 1. sltu with the same operands -> 0. sll by num2=33 -> shift by 1, using the low 5 bits only.
3. Multiply: op=12, 0x0001_0003 x 0x0000_0005 -> busy=1 for 32 cycles, done exactly 32 cycles after start, result=0x0005_000F. start pulsed during busy is ignored (result unchanged).
4. Divide: divu 100/7 -> 14; remu -> 2, each with done after 32 cycles. divu 9/0 -> done after 1 cycle with result=0xFFFFFFFF, busy never 1. remu 9/0 -> 9.
5. Back-to-back and reset abort: start a new add in the done cycle of a mul -> accepted, done the following cycle. Assert rst at iteration 10 of a div -> busy=0, done=0, result=0, and the next op completes normally.
6. With SEQ_ALU_OVERFLOW_EN defined: add 0x7FFFFFFF+1 -> overflow=1. sub 0x80000000-1 -> overflow=1. add 2+3 -> overflow=0.
